rc_approx_pipe_adder: RTL

Parametrised, pipelined ripple-carry adder with a configurable number of approximate LSB cells and per-transaction exact/approximate mode select.
- The carry chain is cut into STAGES register slices.
- Operands move through the slices under a valid/ready handshake.
- Drop-in successor for the fixed 16-bit combinational approximate ripple-carry adders in the adder library, used in delay/error characterisation and accelerator datapaths.

---
 rtl/rc_approx_pipe_adder.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/rc_approx_pipe_adder.sv
// Pipelined ripple-carry adder with approximate LSB cells and valid/ready flow control.
// Optional error monitor (err_dist/err_cnt/err_max) enabled by defining RC_APPROX_ERR_MON_EN.
module rc_approx_pipe_adder #(
  parameter int WIDTH       = 16,
  parameter int APPROX_BITS = 2,
  parameter int STAGES      = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  input  logic             approx_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             out_approx
`ifdef RC_APPROX_ERR_MON_EN
  ,
  output logic [WIDTH:0]   err_dist,
  output logic [31:0]      err_cnt,
  output logic [WIDTH:0]   err_max
`endif
);

  localparam int SEG  = (WIDTH + STAGES - 1) / STAGES;
  localparam int LAST = STAGES - 1;

  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic             c_q  [STAGES];
  logic             ap_q [STAGES];
  logic             v_q  [STAGES];

  logic [WIDTH-1:0] a_src [STAGES];
  logic [WIDTH-1:0] b_src [STAGES];
  logic [WIDTH-1:0] s_src [STAGES];
  logic             c_src  [STAGES];
  logic             ap_src [STAGES];
  logic             v_src  [STAGES];
  logic [WIDTH-1:0] nxt_s [STAGES];
  logic             nxt_c [STAGES];

`ifdef RC_APPROX_ERR_MON_EN
  logic [WIDTH-1:0] ex_q   [STAGES];
  logic             ec_q   [STAGES];
  logic [WIDTH-1:0] ex_src [STAGES];
  logic             ec_src [STAGES];
  logic [WIDTH-1:0] nxt_x  [STAGES];
  logic             nxt_xc [STAGES];
`endif

  logic adv;

  assign adv        = ~(out_valid & ~out_ready);
  assign in_ready   = adv;
  assign out_valid  = v_q[LAST];
  assign sum        = {c_q[LAST], s_q[LAST]};
  assign out_approx = ap_q[LAST];

  // Slice k only evaluates bits [k*SEG, (k+1)*SEG); all other bits pass through.
  always_comb begin
    logic x, y, z, zx;
    x = 1'b0;
    y = 1'b0;
    z = 1'b0;
    zx = 1'b0;
    a_src[0]  = in1;
    b_src[0]  = in2;
    s_src[0]  = '0;
    c_src[0]  = cin;
    ap_src[0] = approx_en;
    v_src[0]  = in_valid;
`ifdef RC_APPROX_ERR_MON_EN
    ex_src[0] = '0;
    ec_src[0] = cin;
`endif
    for (int k = 1; k < STAGES; k++) begin
      a_src[k]  = a_q[k-1];
      b_src[k]  = b_q[k-1];
      s_src[k]  = s_q[k-1];
      c_src[k]  = c_q[k-1];
      ap_src[k] = ap_q[k-1];
      v_src[k]  = v_q[k-1];
`ifdef RC_APPROX_ERR_MON_EN
      ex_src[k] = ex_q[k-1];
      ec_src[k] = ec_q[k-1];
`endif
    end
    for (int k = 0; k < STAGES; k++) begin
      z        = c_src[k];
      nxt_s[k] = s_src[k];
`ifdef RC_APPROX_ERR_MON_EN
      zx       = ec_src[k];
      nxt_x[k] = ex_src[k];
`endif
      for (int i = 0; i < WIDTH; i++) begin
        if (i >= k * SEG && i < (k + 1) * SEG) begin
          x = a_src[k][i];
          y = b_src[k][i];
`ifdef RC_APPROX_ERR_MON_EN
          nxt_x[k][i] = x ^ y ^ zx;
          zx = (x & y) | (x & zx) | (y & zx);
`endif
          if (ap_src[k] && i < APPROX_BITS) begin
            nxt_s[k][i] = (x | y | z) & ~(x & y & z);
            z = y & (x | z);
          end else begin
            nxt_s[k][i] = x ^ y ^ z;
            z = (x & y) | (x & z) | (y & z);
          end
        end
      end
      nxt_c[k] = z;
`ifdef RC_APPROX_ERR_MON_EN
      nxt_xc[k] = zx;
`endif
    end
  end

  // Whole pipe advances together; payload only loads with a valid beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k]  <= 1'b0;
        a_q[k]  <= '0;
        b_q[k]  <= '0;
        s_q[k]  <= '0;
        c_q[k]  <= 1'b0;
        ap_q[k] <= 1'b0;
`ifdef RC_APPROX_ERR_MON_EN
        ex_q[k] <= '0;
        ec_q[k] <= 1'b0;
`endif
      end
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= v_src[k];
        if (v_src[k]) begin
          a_q[k]  <= a_src[k];
          b_q[k]  <= b_src[k];
          s_q[k]  <= nxt_s[k];
          c_q[k]  <= nxt_c[k];
          ap_q[k] <= ap_src[k];
`ifdef RC_APPROX_ERR_MON_EN
          ex_q[k] <= nxt_x[k];
          ec_q[k] <= nxt_xc[k];
`endif
        end
      end
    end
  end

`ifdef RC_APPROX_ERR_MON_EN
  logic [WIDTH:0] exact_o;
  logic [WIDTH:0] dist;

  assign exact_o = {ec_q[LAST], ex_q[LAST]};
  assign dist    = (sum >= exact_o) ? (sum - exact_o) : (exact_o - sum);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_dist <= '0;
      err_cnt  <= '0;
      err_max  <= '0;
    end else if (out_valid && out_ready) begin
      err_dist <= dist;
      if (dist != '0 && err_cnt != 32'hFFFF_FFFF) err_cnt <= err_cnt + 32'd1;
      if (dist > err_max) err_max <= dist;
    end
  end
`endif

endmodule
